// File: rtl/demux_1to4_8b_buf.sv
// 1-to-4 demultiplexer with one holding register per output port.
// An accepted input byte is registered into the target port and is held
// there, with its valid flag set, until that port's consumer takes it.
// Optional feature: define DEMUX_RR_EN to ignore sel and distribute bytes
// round-robin over ports 0..3 (pointer advances only on accept).
module demux_1to4_8b_buf #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready
);

   logic [WIDTH-1:0] data_q [4];
   logic [WIDTH-1:0] data_d [4];
   logic [3:0]       full_q;
   logic [3:0]       full_d;
   logic [1:0]       tgt;
   logic             accept;

`ifdef DEMUX_RR_EN
   logic [1:0] ptr_q;
   logic [1:0] ptr_d;
   logic       unused_sel;

   // sel has no role in round-robin mode
   assign unused_sel = ^sel;
   assign tgt        = ptr_q;
`else
   assign tgt = sel;
`endif

   // A full target can still accept if it is being drained this cycle
   assign in_ready = ~full_q[tgt] | out_ready[tgt];
   assign accept   = in_valid & in_ready;

   // Next-state: drains clear flags, an accept then (re)loads the target port
   always_comb begin
      full_d = full_q;
      for (int i = 0; i < 4; i++) begin
         data_d[i] = data_q[i];
         if (full_q[i] && out_ready[i]) begin
            full_d[i] = 1'b0;
         end
      end
      if (accept) begin
         full_d[tgt] = 1'b1;
         data_d[tgt] = in;
      end
   end

`ifdef DEMUX_RR_EN
   // Pointer advances only on accept; stalls on a blocked port
   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = ptr_q + 2'd1;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 2'd0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // Holding registers and full flags
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         full_q <= full_d;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign out_valid = full_q;
   assign a         = data_q[0];
   assign b         = data_q[1];
   assign c         = data_q[2];
   assign d         = data_q[3];

endmodule

// File: tb/tb_demux_1to4_8b_buf.sv
// Self-checking bench for demux_1to4_8b_buf: directed scenarios followed by
// random traffic, all compared against a behavioural model of the ports.
module tb_demux_1to4_8b_buf;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din = 8'h00;
   logic [1:0] sel = 2'b00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a, b, c, d;
   logic [3:0] out_valid;
   logic [3:0] out_ready = 4'b0000;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: each port holds at most one byte; rr pointer used only in RR builds
   int m_data [4];
   bit m_full [4];
   int m_ptr;

   demux_1to4_8b_buf #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (din),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic int target(input logic [1:0] s);
`ifdef DEMUX_RR_EN
      return m_ptr;
`else
      return int'(s);
`endif
   endfunction

   function automatic logic [3:0] exp_valid();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = m_full[i];
      return v;
   endfunction

   // One clock cycle: drive, check in_ready, clock, update model, check outputs
   task automatic step(input logic r, input logic [7:0] x, input logic [1:0] s,
                       input logic v, input logic [3:0] rdy);
      int  t;
      bit  acc;
      rst = r; din = x; sel = s; in_valid = v; out_ready = rdy;
      #1;
      t = target(s);
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_full[t] || rdy[t])});
      acc = v && (!m_full[t] || rdy[t]);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            m_full[i] = 0;
            m_data[i] = 0;
         end
         m_ptr = 0;
      end else begin
         for (int i = 0; i < 4; i++) if (m_full[i] && rdy[i]) m_full[i] = 0;
         if (acc) begin
            m_data[t] = x;
            m_full[t] = 1;
            m_ptr     = (m_ptr + 1) % 4;
         end
      end
      #1;
      chk("out_valid", {28'd0, out_valid}, {28'd0, exp_valid()});
      chk("a", {24'd0, a}, m_data[0]);
      chk("b", {24'd0, b}, m_data[1]);
      chk("c", {24'd0, c}, m_data[2]);
      chk("d", {24'd0, d}, m_data[3]);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         m_data[i] = 0;
         m_full[i] = 0;
      end
      m_ptr = 0;
      @(negedge clk);

      // Reset state
      step(1'b1, 8'h00, 2'b00, 1'b0, 4'b0000);
      step(1'b1, 8'h00, 2'b00, 1'b0, 4'b0000);
      chk("reset_out_valid", {28'd0, out_valid}, 32'h0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'h1);

      // Fill all four ports with no consumer ready
      step(1'b0, 8'hAA, 2'b00, 1'b1, 4'b0000);
      step(1'b0, 8'h55, 2'b01, 1'b1, 4'b0000);
      step(1'b0, 8'hCC, 2'b10, 1'b1, 4'b0000);
      step(1'b0, 8'h33, 2'b11, 1'b1, 4'b0000);
`ifndef DEMUX_RR_EN
      chk("fill_a", {24'd0, a}, 32'hAA);
      chk("fill_b", {24'd0, b}, 32'h55);
      chk("fill_c", {24'd0, c}, 32'hCC);
      chk("fill_d", {24'd0, d}, 32'h33);
`endif
      chk("fill_valid", {28'd0, out_valid}, 32'hF);

      // Port a blocked, then drain-and-refill in one cycle
      step(1'b0, 8'h11, 2'b00, 1'b1, 4'b0000);
      step(1'b0, 8'h11, 2'b00, 1'b1, 4'b0001);
`ifndef DEMUX_RR_EN
      chk("refill_a", {24'd0, a}, 32'h11);
`endif

      // All full, reset with in_valid high discards everything
      step(1'b1, 8'h77, 2'b00, 1'b1, 4'b0000);
      chk("rst_mid_valid", {28'd0, out_valid}, 32'h0);
      chk("rst_mid_a", {24'd0, a}, 32'h0);

      // b full, drain b while accepting into a
      step(1'b0, 8'h55, 2'b01, 1'b1, 4'b0000);
      step(1'b0, 8'hC3, 2'b00, 1'b1, 4'b0010);
`ifndef DEMUX_RR_EN
      chk("indep_valid", {28'd0, out_valid}, 32'h1);
      chk("indep_a", {24'd0, a}, 32'hC3);
      chk("indep_b_hold", {24'd0, b}, 32'h55);
`endif

      // Idle cycle with ready on empty ports changes nothing
      step(1'b0, 8'hEE, 2'b11, 1'b0, 4'b1111);
      step(1'b0, 8'hEE, 2'b01, 1'b0, 4'b1111);

      // Five bytes with every consumer ready
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 8'(i), 2'(i * 3), 1'b1, 4'b1111);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 29) == 0), 8'($urandom), 2'($urandom),
              1'($urandom), 4'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/demux_1to4_8b_buf.md
DEMUX_1TO4_8B_BUF -- requirements
Module: demux_1to4_8b_buf

Interface
REQ-001 Parameter WIDTH, default 8, data width of the input and of each output port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in  input  WIDTH  byte to be distributed.
REQ-005 sel  input  2  destination port select: 00->a, 01->b, 10->c, 11->d.
REQ-006 in_valid  input  1  producer has a byte on in.
REQ-007 in_ready  output  1  block accepts the byte this cycle.
REQ-008 a, b, c, d  output  WIDTH each  registered output data, ports 0..3.
REQ-009 out_valid  output  4  bit i set = port i holds an undelivered byte.
REQ-010 out_ready  input  4  bit i set = consumer of port i takes the byte this cycle.

Function
REQ-011 Each port SHALL have one holding register (data plus full flag); out_valid[i] SHALL equal full[i].
REQ-012 Target port t SHALL be sel, or the round-robin pointer when DEMUX_RR_EN is defined.
REQ-013 in_ready SHALL be combinational: ~full[t] | out_ready[t]; it SHALL NOT depend on in_valid.
REQ-014 Accept = in_valid & in_ready; on accept the port t data register SHALL load in and full[t] SHALL set.
REQ-015 Latency SHALL be one cycle: accepted byte appears on port t with out_valid[t]=1 the next cycle.
REQ-016 Drain = full[i] & out_ready[i]; on drain without refill, full[i] SHALL clear.
REQ-017 Drain and accept on the same port in one cycle SHALL keep full[t]=1 and load the new byte (no bubble).
REQ-018 Accept on port t and drains on other ports SHALL proceed independently in the same cycle.
REQ-019 Data registers SHALL hold their last value after drain; only full flags change.
REQ-020 out_ready[i] while full[i]=0 SHALL have no effect.
REQ-021 in_valid=0 SHALL never change any data register or the pointer.
REQ-022 Port state SHALL not change while full and out_ready=0 (data and valid stable until taken).

Reset
REQ-023 While rst=1 at a clock edge: full flags -> 0, a/b/c/d -> 0, pointer -> 0; in_ready SHALL show ~full[t]|out_ready[t] with full cleared (i.e. 1).
REQ-024 rst asserted mid-transfer SHALL discard all held bytes; in_valid the same cycle SHALL be ignored (no accept).
REQ-025 First accept possible on the first edge after rst deasserts.

Configuration
REQ-026 Macro DEMUX_RR_EN defined: sel ignored; 2-bit pointer selects t, starts 0, increments by 1 only on accept, wraps 3->0.
REQ-027 With DEMUX_RR_EN, if port t is full and not draining, in_ready=0 and the pointer SHALL stall (no skipping to a free port).
REQ-028 DEMUX_RR_EN undefined: sel selects t every cycle; no pointer logic present; sel may change every cycle.

Verification
REQ-029 Reset, then sel=00,01,10,11 with in=AA,55,CC,33, in_valid=1, out_ready=0 -> a=AA,b=55,c=CC,d=33, out_valid=1111 one cycle after each accept, in_ready=1 each cycle.
REQ-030 Port a full (AA), out_ready=0, sel=00, in=11 -> in_ready=0, a stays AA; raise out_ready[0] -> same cycle in_ready=1, next cycle a=11, out_valid[0]=1.
REQ-031 Ports b full, out_ready=0010, sel=00 in=C3 accepted -> next cycle out_valid=0001, a=C3, b holds 55.
REQ-032 All ports full, rst=1 with in_valid=1 -> next cycle out_valid=0000, a..d=00, no byte accepted.
REQ-033 DEMUX_RR_EN: five bytes 01..05, out_ready=1111 -> 01 on a, 02 b, 03 c, 04 d, 05 on a (wrap), sel ignored.
REQ-034 DEMUX_RR_EN: port b full, out_ready=0, pointer=1 -> in_ready=0, pointer stays 1 until b drains.
